bound_flasher_gen: RTL and testbench

BOUND_FLASHER_GEN -- requirements
Module: bound_flasher_gen

---
 rtl/bound_flasher_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_bound_flasher_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_gen.sv
//------------------------------------------------------------------------------
// bound_flasher_gen
//
// Purpose:
//   Lamp-bar flasher. A counter c holds the number of lit lamps, and the bar
//   fills from the LSB upward. After a flick request in IDLE, the counter walks
//   through six phases:
//     UP1 0->B1, DOWN1 B1->0, UP2 0->B2, DOWN2 B2->B1, UP3 B1->N, DOWN3 N->0
//   On reaching each target the counter dwells for one tick, then the next
//   phase starts. A flick while the counter sits on a bound in UP2 or UP3
//   kicks the sequence back to an earlier down phase.
//
// Parameters:
//   N  : number of LEDs
//   B1 : first bound / low kickback point
//   B2 : second bound / high kickback point
//   The parameters must satisfy 0 < B1 < B2 < N.
//
// Ports:
//   clk   in   1     rising-edge clock
//   rst   in   1     synchronous active-high reset
//   tick  in   1     one-cycle step enable; nothing advances without it
//   flick in   1     active-high flick request (debounced)
//   led   out  N     lamp bar, led[i] = (i < c)
//   max   out  CW    upper bound of the current phase
//   min   out  CW    lower bound of the current phase
//   phase out  3     current FSM state code
//   busy  out  1     high whenever phase != IDLE
//------------------------------------------------------------------------------
module bound_flasher_gen #(
   parameter  int N  = 16,
   parameter  int B1 = 5,
   parameter  int B2 = 10,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          flick,
   output logic [N-1:0]  led,
   output logic [CW-1:0] max,
   output logic [CW-1:0] min,
   output logic [2:0]    phase,
   output logic          busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_UP1   = 3'd1,
      ST_DOWN1 = 3'd2,
      ST_UP2   = 3'd3,
      ST_DOWN2 = 3'd4,
      ST_UP3   = 3'd5,
      ST_DOWN3 = 3'd6
   } state_t;

   localparam logic [CW-1:0] C_ZERO = '0;
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_B1   = CW'(B1);
   localparam logic [CW-1:0] C_B2   = CW'(B2);
   localparam logic [CW-1:0] C_N    = CW'(N);

   state_t         r_state;
   logic [CW-1:0]  r_c;
   logic [N-1:0]   r_led;
   logic [CW-1:0]  r_max;
   logic [CW-1:0]  r_min;
   logic           r_busy;

   state_t         w_state_nxt;
   logic [CW-1:0]  w_c_nxt;
   logic [N-1:0]   w_led_nxt;
   logic [CW-1:0]  w_max_nxt;
   logic [CW-1:0]  w_min_nxt;
   logic           w_busy_nxt;
   logic [N-1:0]   w_ones;

   assign w_ones = '1;

   //---------------------------------------------------------------------------
   // State / counter register. The outputs are registered from the *next*
   // values, so they always agree with the state and counter in the same cycle.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_c     <= '0;
         r_led   <= '0;
         r_max   <= '0;
         r_min   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_c     <= w_c_nxt;
         r_led   <= w_led_nxt;
         r_max   <= w_max_nxt;
         r_min   <= w_min_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state / counter logic.
   // Bound tests use >= (up) and <= (down) rather than ==. In reachable states
   // this gives the same result, and it guarantees the counter can never step
   // past a target and wrap.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_c_nxt     = r_c;

      case (r_state)
         ST_IDLE: begin
            if (tick) begin
               w_c_nxt = C_ZERO;
               if (flick) begin
                  w_state_nxt = ST_UP1;
               end
            end
         end

         ST_UP1: begin
            if (tick) begin
               if (r_c >= C_B1) begin
                  w_state_nxt = ST_DOWN1;
               end else begin
                  w_c_nxt = r_c + C_ONE;
               end
            end
         end

         ST_DOWN1: begin
            if (tick) begin
               if (r_c == C_ZERO) begin
                  w_state_nxt = ST_UP2;
               end else begin
                  w_c_nxt = r_c - C_ONE;
               end
            end
         end

         ST_UP2: begin
            if (tick) begin
               // The kickback is tested first so that it overrides the dwell at B2.
               if (flick && ((r_c == C_B1) || (r_c == C_B2))) begin
                  w_state_nxt = ST_DOWN1;
               end else if (r_c >= C_B2) begin
                  w_state_nxt = ST_DOWN2;
               end else begin
                  w_c_nxt = r_c + C_ONE;
               end
            end
         end

         ST_DOWN2: begin
            if (tick) begin
               if (r_c <= C_B1) begin
                  w_state_nxt = ST_UP3;
               end else begin
                  w_c_nxt = r_c - C_ONE;
               end
            end
         end

         ST_UP3: begin
            if (tick) begin
               if (flick && (r_c == C_B2)) begin
                  w_state_nxt = ST_DOWN2;
               end else if (r_c >= C_N) begin
                  w_state_nxt = ST_DOWN3;
               end else begin
                  w_c_nxt = r_c + C_ONE;
               end
            end
         end

         ST_DOWN3: begin
            if (tick) begin
               if (r_c == C_ZERO) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_c_nxt = r_c - C_ONE;
               end
            end
         end

         // The unused code 7 recovers to IDLE on the next edge, even without a tick.
         default: begin
            w_state_nxt = ST_IDLE;
            w_c_nxt     = C_ZERO;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Output decode from the next state / counter.
   //---------------------------------------------------------------------------
   always_comb begin
      w_max_nxt = C_ZERO;
      w_min_nxt = C_ZERO;

      case (w_state_nxt)
         ST_UP1, ST_DOWN1: begin
            w_max_nxt = C_B1;
         end
         ST_UP2: begin
            w_max_nxt = C_B2;
         end
         ST_DOWN2: begin
            w_max_nxt = C_B2;
            w_min_nxt = C_B1;
         end
         ST_UP3: begin
            w_max_nxt = C_N;
            w_min_nxt = C_B1;
         end
         ST_DOWN3: begin
            w_max_nxt = C_N;
         end
         default: begin
            w_max_nxt = C_ZERO;
            w_min_nxt = C_ZERO;
         end
      endcase

      // Shifting ones out from the bottom leaves exactly c low bits lit after
      // the inversion. A shift by c = N clears every bit, so the bar is full.
      w_led_nxt  = ~(w_ones << w_c_nxt);
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   assign led   = r_led;
   assign max   = r_max;
   assign min   = r_min;
   assign phase = r_state;
   assign busy  = r_busy;

endmodule

// File: tb/tb_bound_flasher_gen.sv
//------------------------------------------------------------------------------
// tb_bound_flasher_gen
//
// Directed, self-checking bench for bound_flasher_gen with N=16, B1=5, B2=10.
// Inputs are driven on the falling edge. Outputs are checked at the following
// falling edge, which is one rising edge later.
//------------------------------------------------------------------------------
module tb_bound_flasher_gen;

   localparam int N  = 16;
   localparam int B1 = 5;
   localparam int B2 = 10;
   localparam int CW = $clog2(N + 1);

   logic          clk;
   logic          rst;
   logic          tick;
   logic          flick;
   logic [N-1:0]  led;
   logic [CW-1:0] max;
   logic [CW-1:0] min;
   logic [2:0]    phase;
   logic          busy;

   int n_checks;
   int n_fail;

   bound_flasher_gen #(
      .N  (N),
      .B1 (B1),
      .B2 (B2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .flick (flick),
      .led   (led),
      .max   (max),
      .min   (min),
      .phase (phase),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       t;
      logic       f;
      logic [2:0] ph;
      int         c;
      string      nm;
   } vec_t;

   typedef struct {
      logic [2:0] ph;
      int         c;
   } st_t;

   function automatic int exp_max(input logic [2:0] ph);
      case (ph)
         3'd1, 3'd2: return 5;
         3'd3, 3'd4: return 10;
         3'd5, 3'd6: return 16;
         default:    return 0;
      endcase
   endfunction

   function automatic int exp_min(input logic [2:0] ph);
      case (ph)
         3'd4, 3'd5: return 5;
         default:    return 0;
      endcase
   endfunction

   task automatic apply(input logic r, input logic t, input logic f);
      rst   = r;
      tick  = t;
      flick = f;
      @(negedge clk);
   endtask

   task automatic check(input string nm, input logic [2:0] ph, input int c);
      logic [31:0]   full;
      logic [N-1:0]  e_led;
      logic [CW-1:0] e_max;
      logic [CW-1:0] e_min;
      logic          e_busy;
      full   = (32'd1 << c) - 32'd1;
      e_led  = full[N-1:0];
      e_max  = CW'(exp_max(ph));
      e_min  = CW'(exp_min(ph));
      e_busy = (ph != 3'd0);
      n_checks++;
      if (led !== e_led || phase !== ph || max !== e_max || min !== e_min || busy !== e_busy) begin
         n_fail++;
         $display("FAIL %s: got led=%h phase=%0d max=%0d min=%0d busy=%b, expected led=%h phase=%0d max=%0d min=%0d busy=%b",
                  nm, led, phase, max, min, busy, e_led, ph, e_max, e_min, e_busy);
      end
   endtask

   task automatic go(input string nm, input int n, input logic [2:0] ph, input int c);
      repeat (n) apply(1'b0, 1'b1, 1'b0);
      check(nm, ph, c);
   endtask

   // Reset, start a sequence, and walk it to the first cycle of UP2 (c = 0).
   task automatic to_up2_zero(input string nm);
      apply(1'b1, 1'b0, 1'b0);
      check({nm, "_rst"}, 3'd0, 0);
      apply(1'b0, 1'b1, 1'b1);
      check({nm, "_start"}, 3'd1, 0);
      go({nm, "_up1_top"}, 5, 3'd1, 5);
      go({nm, "_down1_in"}, 1, 3'd2, 5);
      go({nm, "_down1_bot"}, 5, 3'd2, 0);
      go({nm, "_up2_in"}, 1, 3'd3, 0);
   endtask

   vec_t vt[10];
   st_t  traj[$];

   initial begin
      int seg_ph[6];
      int seg_end[6];
      int c;

      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      tick     = 1'b0;
      flick    = 1'b0;

      // Basic vectors: reset, tick gating, start, flick ignored in UP1, reset override.
      vt[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 0, "reset"};
      vt[1] = '{1'b0, 1'b1, 1'b0, 3'd0, 0, "idle_no_flick"};
      vt[2] = '{1'b0, 1'b0, 1'b1, 3'd0, 0, "flick_without_tick"};
      vt[3] = '{1'b0, 1'b1, 1'b1, 3'd1, 0, "start_no_step"};
      vt[4] = '{1'b0, 1'b0, 1'b1, 3'd1, 0, "up1_gated"};
      vt[5] = '{1'b0, 1'b1, 1'b1, 3'd1, 1, "up1_flick_ignored"};
      vt[6] = '{1'b0, 1'b1, 1'b0, 3'd1, 2, "up1_step"};
      vt[7] = '{1'b1, 1'b1, 1'b1, 3'd0, 0, "reset_overrides"};
      vt[8] = '{1'b0, 1'b1, 1'b0, 3'd0, 0, "post_reset_idle"};
      vt[9] = '{1'b0, 1'b1, 1'b1, 3'd1, 0, "restart"};

      for (int i = 0; i < 10; i++) begin
         apply(vt[i].r, vt[i].t, vt[i].f);
         check(vt[i].nm, vt[i].ph, vt[i].c);
      end

      // Full sequence: the expected trajectory is built from the phase/target list.
      seg_ph  = '{1, 2, 3, 4, 5, 6};
      seg_end = '{5, 0, 10, 5, 16, 0};
      c = 0;
      for (int s = 0; s < 6; s++) begin
         while (c != seg_end[s]) begin
            c = (seg_end[s] > c) ? c + 1 : c - 1;
            traj.push_back('{3'(seg_ph[s]), c});
         end
         traj.push_back('{(s == 5) ? 3'd0 : 3'(seg_ph[s+1]), c});
      end

      apply(1'b1, 1'b0, 1'b0);
      check("full_rst", 3'd0, 0);
      apply(1'b0, 1'b1, 1'b1);
      check("full_start", 3'd1, 0);
      foreach (traj[k]) begin
         apply(1'b0, 1'b1, 1'b0);
         check("full_seq", traj[k].ph, traj[k].c);
      end

      // Idle hold.
      for (int i = 0; i < 100; i++) begin
         apply(1'b0, 1'b1, 1'b0);
         check("idle_hold", 3'd0, 0);
      end

      // Kickback in UP2 at c = B1.
      to_up2_zero("kb2a");
      go("kb2a_up2_b1", 5, 3'd3, 5);
      apply(1'b0, 1'b1, 1'b1);
      check("kb2a_kick", 3'd2, 5);
      go("kb2a_down", 1, 3'd2, 4);

      // In UP2, flick is ignored off-bound; kickback at c = B2 beats the dwell.
      to_up2_zero("kb2b");
      go("kb2b_up2_7", 7, 3'd3, 7);
      apply(1'b0, 1'b1, 1'b1);
      check("kb2b_flick_ignored", 3'd3, 8);
      go("kb2b_up2_b2", 2, 3'd3, 10);
      apply(1'b0, 1'b1, 1'b1);
      check("kb2b_kick_b2", 3'd2, 10);
      go("kb2b_down", 1, 3'd2, 9);

      // Tick gating mid-UP2 with c = 7.
      to_up2_zero("gate");
      go("gate_up2_7", 7, 3'd3, 7);
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 1'b0, (i % 2) == 0);
         check("gate_hold", 3'd3, 7);
      end
      go("gate_resume", 1, 3'd3, 8);

      // Kickback in UP3 at c = B2, then back into UP3 at B1.
      to_up2_zero("kb3");
      go("kb3_up2_top", 10, 3'd3, 10);
      go("kb3_down2_in", 1, 3'd4, 10);
      go("kb3_down2_b1", 5, 3'd4, 5);
      go("kb3_up3_in", 1, 3'd5, 5);
      go("kb3_up3_b2", 5, 3'd5, 10);
      apply(1'b0, 1'b1, 1'b1);
      check("kb3_kick", 3'd4, 10);
      go("kb3_step", 1, 3'd4, 9);
      apply(1'b0, 1'b1, 1'b1);
      check("kb3_down2_flick_ignored", 3'd4, 8);
      go("kb3_down2_b1_again", 3, 3'd4, 5);
      go("kb3_up3_again", 1, 3'd5, 5);

      // Reset mid-DOWN2 with c = 8, then a fresh start.
      to_up2_zero("rmid");
      go("rmid_up2_top", 10, 3'd3, 10);
      go("rmid_down2_in", 1, 3'd4, 10);
      go("rmid_down2_8", 2, 3'd4, 8);
      apply(1'b1, 1'b1, 1'b1);
      check("rmid_reset", 3'd0, 0);
      apply(1'b0, 1'b1, 1'b0);
      check("rmid_idle", 3'd0, 0);
      apply(1'b0, 1'b1, 1'b1);
      check("rmid_restart", 3'd1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
